pll_reset_mc: RTL
=================

Name: pll_reset_mc

Overview:
Multi-channel PLL lock supervisor for the data-channel deserialiser PLLs. It is a parametrised successor to the single-PLL reset generator, with these additions:
- N independent channels.
- Lock-loss glitch filtering.
- Bounded retry with a sticky per-channel fault.
- A software fault-clear input.
- A global hold-in-reset while sensor init is incomplete.

It sits between the PLL lock outputs and the PLL RST pins, in the same clock domain as the fabric check clock.

Parameters:
NUM_PLL, 2, number of supervised PLL channels (1..8).
CLK_PERIOD_NS, 25, period of clk in ns.
RESET_TIME_NS, 500000, reset pulse width in ns.
WAIT_TIME_NS, 2000000, lock wait window after reset release, in ns.
LOCK_FILTER_CYCLES, 4, consecutive synchronised-low cycles that count as lock loss (1..15).
MAX_RETRY, 7, failed reset attempts before a channel enters fault (1..15).
SIMULATION, "FALSE", when "TRUE": RESET_CNT_NUM=10 and WAIT_CNT_NUM=100; otherwise each count is TIME_NS/CLK_PERIOD_NS.

Ports:
clk  input  1  supervisor clock.
reset  input  1  reset; asynchronous, active-high.
i_pll_lock  input  NUM_PLL  raw PLL LOCKED, asynchronous; bit i belongs to channel i.
i_sensor_init_done  input  1  low means hold all PLLs in reset.
i_fault_clr  input  NUM_PLL  single-cycle pulse; clears the fault on channel i.
o_pll_reset  output  NUM_PLL  PLL reset, active-high.
o_pll_locked  output  NUM_PLL  channel is in S_MON, i.e. filtered lock is good.
o_fault  output  NUM_PLL  sticky; channel exhausted its retries.
o_retry_cnt  output  4*NUM_PLL  current retry count per channel; channel i occupies bits [4i+3:4i].
o_loss_cnt  output  8*NUM_PLL  lock-loss event counters; exists only with the optional feature, otherwise constant 0.

Behaviour:
- Reset values (state after reset):
  - Every channel is in S_MON.
  - All counters are 0.
  - Sync flops are 1.
  - o_pll_reset follows only !i_sensor_init_done.
  - o_pll_locked = 0 until the first valid lock, see the S_MON rule.
  - o_fault = 0.
- Per channel, a 2-flop synchroniser produces lock_s. All control uses lock_s.
- Global hold: while i_sensor_init_done = 0:
  - every channel is forced to S_MON;
  - filter, reset, wait and retry counters are cleared;
  - o_fault is preserved;
  - o_pll_reset is all ones.
- Channel FSM, one registered state per channel:
  - S_MON:
    - filt_cnt increments while lock_s=0 and clears while lock_s=1.
    - When filt_cnt reaches LOCK_FILTER_CYCLES-1 with lock_s=0, the next state is S_RST and o_loss_cnt increments.
    - o_pll_locked = lock_s AND (filt_cnt==0).
  - S_RST:
    - o_pll_reset=1 for exactly RESET_CNT_NUM cycles (rst_cnt runs 0..RESET_CNT_NUM-1), then S_WAIT.
  - S_WAIT:
    - wait_cnt runs 0..WAIT_CNT_NUM-1.
    - At the last count, if lock_s=1: go to S_MON and clear retry_cnt.
    - At the last count, if lock_s=0: retry_cnt+1. If the new value equals MAX_RETRY, go to S_FAULT; otherwise go to S_RST.
    - Lock rising early does not shorten the wait.
  - S_FAULT:
    - o_fault=1, o_pll_reset=0 (the PLL is left released for debug).
    - i_fault_clr[i] moves the channel to S_RST and clears both retry_cnt and o_fault on the same edge.
- o_pll_reset[i] = (state==S_RST) OR !i_sensor_init_done, decoded from registered state only.
- Latency: lock falls at edge 0, then o_pll_reset rises LOCK_FILTER_CYCLES+2 edges later (2 synchroniser cycles + filter).
- i_fault_clr outside S_FAULT is ignored.
- Counter widths are clog2(N+1); retry_cnt saturates at MAX_RETRY.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- Async reset mid-operation returns every channel to its reset state immediately; o_pll_reset drops within the same cycle unless init_done=0.

Optional Feature:
PLL_RESET_STAT_EN
- Defined: o_loss_cnt carries an 8-bit per-channel counter that increments on each S_MON to S_RST transition. It saturates at 255 and is cleared only by reset.
- Undefined: the counter logic is absent and o_loss_cnt is tied to 0.

Test Plan:
All scenarios use SIMULATION="TRUE", NUM_PLL=2, LOCK_FILTER_CYCLES=4, MAX_RETRY=3.
1. init_done=0 with locks=2'b11 -> o_pll_reset=2'b11 and o_pll_locked=0. Raise init_done -> o_pll_reset=0, o_pll_locked=2'b11 three cycles later.
2. Ch0 lock low for 3 cycles, then high -> no reset and o_loss_cnt[0]=0. Lock low for 10 cycles -> o_pll_reset[0]=1 for exactly 10 cycles, starting 6 edges after the lock fell. Ch1 stays untouched.
3. Ch0 lock held low -> reset pulses repeat 3 times, each 10 cycles high separated by 100 cycles low. Then o_fault[0]=1, o_retry_cnt[0]=3, o_pll_reset[0]=0 steady.
4. In fault, pulse i_fault_clr[0] -> o_fault[0]=0, o_retry_cnt[0]=0, new 10-cycle reset. Lock returns within the wait window -> S_MON, o_pll_locked[0]=1. i_fault_clr[1] pulsed on the healthy ch1 has no effect.
5. Assert reset mid-S_RST -> o_pll_reset clears asynchronously and the counters read 0.
6. With PLL_RESET_STAT_EN: 260 lock-loss events -> o_loss_cnt[0]=255. Without the macro -> o_loss_cnt=0.

Source files
------------

// File: rtl/pll_reset_mc.sv
// pll_reset_mc: multi-channel PLL lock supervisor with lock-loss filter, bounded retry and sticky fault.
// Define PLL_RESET_STAT_EN to build the per-channel 8-bit lock-loss counters on o_loss_cnt.
module pll_reset_mc #(
  parameter int    NUM_PLL            = 2,
  parameter int    CLK_PERIOD_NS      = 25,
  parameter int    RESET_TIME_NS      = 500000,
  parameter int    WAIT_TIME_NS       = 2000000,
  parameter int    LOCK_FILTER_CYCLES = 4,
  parameter int    MAX_RETRY          = 7,
  parameter string SIMULATION         = "FALSE"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PLL-1:0]   i_pll_lock,
  input  logic                 i_sensor_init_done,
  input  logic [NUM_PLL-1:0]   i_fault_clr,
  output logic [NUM_PLL-1:0]   o_pll_reset,
  output logic [NUM_PLL-1:0]   o_pll_locked,
  output logic [NUM_PLL-1:0]   o_fault,
  output logic [4*NUM_PLL-1:0] o_retry_cnt,
  output logic [8*NUM_PLL-1:0] o_loss_cnt
);

  localparam int RESET_CNT_NUM = (SIMULATION == "TRUE") ? 10  : RESET_TIME_NS / CLK_PERIOD_NS;
  localparam int WAIT_CNT_NUM  = (SIMULATION == "TRUE") ? 100 : WAIT_TIME_NS / CLK_PERIOD_NS;

  localparam int FILT_W  = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam int RST_W   = $clog2(RESET_CNT_NUM + 1);
  localparam int WAIT_W  = $clog2(WAIT_CNT_NUM + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RESET_CNT_NUM - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_CNT_NUM - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {S_MON, S_RST, S_WAIT, S_FAULT} state_t;

  // Lock is only reported once init_done has been seen high for three edges,
  // so a lock seen during the global hold is never reported as good.
  logic [2:0] init_pipe;
  logic       released;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) init_pipe <= 3'b000;
    else       init_pipe <= {init_pipe[1:0], i_sensor_init_done};
  end

  assign released = init_pipe[2] & i_sensor_init_done;

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_ch
    logic [1:0]         sync_q;
    logic               lock_s;
    state_t             state_q, state_d;
    logic [FILT_W-1:0]  filt_q, filt_d;
    logic [RST_W-1:0]   rst_q, rst_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               fault_q, fault_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], i_pll_lock[g]};
    end

    assign lock_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= S_MON;
        filt_q  <= '0;
        rst_q   <= '0;
        wait_q  <= '0;
        retry_q <= '0;
        fault_q <= 1'b0;
      end else begin
        state_q <= state_d;
        filt_q  <= filt_d;
        rst_q   <= rst_d;
        wait_q  <= wait_d;
        retry_q <= retry_d;
        fault_q <= fault_d;
      end
    end

    // The global hold overrides everything except the sticky fault flag.
    always_comb begin
      state_d = state_q;
      filt_d  = filt_q;
      rst_d   = rst_q;
      wait_d  = wait_q;
      retry_d = retry_q;
      fault_d = fault_q;
      if (!i_sensor_init_done) begin
        state_d = S_MON;
        filt_d  = '0;
        rst_d   = '0;
        wait_d  = '0;
        retry_d = '0;
      end else begin
        case (state_q)
          S_MON: begin
            if (lock_s) begin
              filt_d = '0;
            end else if (filt_q == FILT_LAST) begin
              filt_d  = '0;
              state_d = S_RST;
            end else begin
              filt_d = filt_q + FILT_W'(1);
            end
          end
          S_RST: begin
            if (rst_q == RST_LAST) begin
              rst_d   = '0;
              state_d = S_WAIT;
            end else begin
              rst_d = rst_q + RST_W'(1);
            end
          end
          // An early lock does not end the wait; only the final count samples lock.
          S_WAIT: begin
            if (wait_q == WAIT_LAST) begin
              wait_d = '0;
              if (lock_s) begin
                retry_d = '0;
                state_d = S_MON;
              end else if (retry_q == RETRY_LAST) begin
                retry_d = RETRY_MAX;
                fault_d = 1'b1;
                state_d = S_FAULT;
              end else begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = S_RST;
              end
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end
          S_FAULT: begin
            if (i_fault_clr[g]) begin
              retry_d = '0;
              fault_d = 1'b0;
              state_d = S_RST;
            end
          end
          default: state_d = S_MON;
        endcase
      end
    end

    assign o_pll_reset[g]         = (state_q == S_RST) | ~i_sensor_init_done;
    assign o_pll_locked[g]        = released & (state_q == S_MON) & lock_s & (filt_q == '0);
    assign o_fault[g]             = fault_q;
    assign o_retry_cnt[4*g +: 4]  = 4'(retry_q);

`ifdef PLL_RESET_STAT_EN
    logic [7:0] loss_q;
    logic       loss_evt;

    assign loss_evt = (state_q == S_MON) & (state_d == S_RST);

    always_ff @(posedge clk or posedge reset) begin
      if (reset)                             loss_q <= 8'h00;
      else if (loss_evt && loss_q != 8'hFF)  loss_q <= loss_q + 8'h01;
    end

    assign o_loss_cnt[8*g +: 8] = loss_q;
`else
    assign o_loss_cnt[8*g +: 8] = 8'h00;
`endif
  end

endmodule
